// File: rtl/fifo_ctr_dp_if.sv
// ============================================================================
// fifo_ctr_dp_if : request/RAM-control bundle for the dual-port FIFO controller
// Revision 1.0
// ============================================================================
`default_nettype none

interface fifo_ctr_dp_if #(
  parameter int AW = 6
);
  logic          push;
  logic          pop;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          ren;
  logic [AW-1:0] raddr;
  logic          rvalid;
  logic [AW:0]   count;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          underflow;
  logic          error;

  modport master (
    output push, pop,
    input  wen, waddr, ren, raddr, rvalid, count,
    input  empty, almost_empty, full, almost_full,
    input  overflow, underflow, error
  );

  modport slave (
    input  push, pop,
    output wen, waddr, ren, raddr, rvalid, count,
    output empty, almost_empty, full, almost_full,
    output overflow, underflow, error
  );
endinterface

`default_nettype wire

// File: rtl/fifo_ctr_dp.sv
// ============================================================================
// fifo_ctr_dp : pointer/occupancy controller for a synchronous dual-port RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_ctr_dp #(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 63
) (
  input  logic         clk,
  input  logic         rst,
  fifo_ctr_dp_if.slave bus
);

  localparam logic [1:0] c_st_empty  = 2'd0;
  localparam logic [1:0] c_st_active = 2'd1;
  localparam logic [1:0] c_st_full   = 2'd2;

  localparam logic [AW:0] c_one      = (AW+1)'(1);
  localparam logic [AW:0] c_depth_m1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_ae_level = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] c_af_level = (AW+1)'(AF_LEVEL);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_rvalid;
  logic          r_error;
  logic          w_empty;
  logic          w_full;
  logic          w_wacc;
  logic          w_racc;

  // Flags come only from registers, so push/pop never reach them combinationally.
  assign w_empty = (r_state == c_st_empty);
  assign w_full  = (r_state == c_st_full);

  assign w_wacc = bus.push & ~w_full  & ~rst;
  assign w_racc = bus.pop  & ~w_empty & ~rst;

  assign w_count_next = r_count + {{AW{1'b0}}, w_wacc} - {{AW{1'b0}}, w_racc};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_empty: begin
        if (w_wacc) w_state_next = c_st_active;
      end
      c_st_active: begin
        if (r_count == c_one && w_racc && !w_wacc)
          w_state_next = c_st_empty;
        else if (r_count == c_depth_m1 && w_wacc && !w_racc)
          w_state_next = c_st_full;
      end
      c_st_full: begin
        if (w_racc) w_state_next = c_st_active;
      end
      default: w_state_next = c_st_empty;
    endcase
  end

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_st_empty;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_wptr   <= r_wptr + {{(AW-1){1'b0}}, w_wacc};
      r_rptr   <= r_rptr + {{(AW-1){1'b0}}, w_racc};
      r_count  <= w_count_next;
      r_rvalid <= w_racc;
      r_error  <= r_error | bus.overflow | bus.underflow;
    end
  end

  assign bus.wen          = w_wacc;
  assign bus.waddr        = r_wptr;
  assign bus.ren          = w_racc;
  assign bus.raddr        = r_rptr;
  assign bus.rvalid       = r_rvalid;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_count <= c_ae_level);
  assign bus.almost_full  = (r_count >= c_af_level);
  assign bus.overflow     = bus.push & w_full  & ~rst;
  assign bus.underflow    = bus.pop  & w_empty & ~rst;
  assign bus.error        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctr_dp.sv
// ============================================================================
// tb_fifo_ctr_dp : directed self-checking bench for fifo_ctr_dp (DEPTH=8)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ctr_dp;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fifo_ctr_dp_if #(.AW(AW)) bus ();

  fifo_ctr_dp #(
    .DEPTH(DEPTH), .AW(AW), .AE_LEVEL(1), .AF_LEVEL(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; combinational outputs settle by +2.
  task automatic drive(input logic p, input logic q);
    bus.push = p;
    bus.pop  = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic do_pop(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    bus.push = 1'b1;
    bus.pop  = 1'b1;

    // Reset held two cycles with requests active
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("rst_wen", bus.wen, 0);
      check("rst_ren", bus.ren, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_unf", bus.underflow, 0);
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_aempty", bus.almost_empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_afull", bus.almost_full, 0);
      check("rst_error", bus.error, 0);
      check("rst_rvalid", bus.rvalid, 0);
    end
    rst = 1'b0;

    // Fill
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      check("fill_wen", bus.wen, 1);
      check("fill_waddr", bus.waddr, i);
      check("fill_ovf", bus.overflow, 0);
      tick();
      check("fill_count", bus.count, i + 1);
      check("fill_aempty", bus.almost_empty, (i + 1) <= 1);
      check("fill_afull", bus.almost_full, (i + 1) >= 7);
      check("fill_full", bus.full, (i + 1) == 8);
      check("fill_empty", bus.empty, 0);
    end
    drive(1'b1, 1'b0);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_wen", bus.wen, 0);
    tick();
    check("ovf_error", bus.error, 1);
    check("ovf_count", bus.count, 8);
    check("ovf_full", bus.full, 1);

    // Drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      check("drain_ren", bus.ren, 1);
      check("drain_raddr", bus.raddr, i);
      tick();
      check("drain_rvalid", bus.rvalid, 1);
      check("drain_count", bus.count, 7 - i);
      check("drain_empty", bus.empty, i == 7);
      check("drain_full", bus.full, 0);
    end
    drive(1'b0, 1'b0);
    tick();
    check("drain_rvalid_idle", bus.rvalid, 0);
    check("error_sticky", bus.error, 1);

    // Wrap: reset, pre-offset both pointers to 6, then cross 7->0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_rst_error", bus.error, 0);
    do_push(6);
    do_pop(6);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      check("wrap_waddr", bus.waddr, (6 + i) % 8);
      tick();
    end
    check("wrap_count", bus.count, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      check("wrap_raddr", bus.raddr, (6 + i) % 8);
      tick();
    end
    check("wrap_empty", bus.empty, 1);

    // Simultaneous push/pop at count=4 (wptr=1, rptr=1 here)
    do_push(4);
    check("sim_count_pre", bus.count, 4);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      check("sim_wen", bus.wen, 1);
      check("sim_ren", bus.ren, 1);
      check("sim_waddr", bus.waddr, (5 + i) % 8);
      check("sim_raddr", bus.raddr, (1 + i) % 8);
      tick();
      check("sim_count", bus.count, 4);
    end
    check("sim_wptr", bus.waddr, 2);
    check("sim_rptr", bus.raddr, 6);

    // Simultaneous at empty
    do_pop(4);
    check("sime_empty", bus.empty, 1);
    check("sime_error_pre", bus.error, 0);
    drive(1'b1, 1'b1);
    check("sime_wen", bus.wen, 1);
    check("sime_ren", bus.ren, 0);
    check("sime_unf", bus.underflow, 1);
    check("sime_waddr", bus.waddr, 2);
    tick();
    check("sime_count", bus.count, 1);
    check("sime_error", bus.error, 1);
    check("sime_rvalid", bus.rvalid, 0);

    // Simultaneous at full
    do_push(7);
    check("simf_full", bus.full, 1);
    drive(1'b1, 1'b1);
    check("simf_ren", bus.ren, 1);
    check("simf_wen", bus.wen, 0);
    check("simf_ovf", bus.overflow, 1);
    check("simf_raddr", bus.raddr, 2);
    tick();
    check("simf_count", bus.count, 7);
    check("simf_full_after", bus.full, 0);
    check("simf_rvalid", bus.rvalid, 1);

    // Reset mid-operation at count=5 with a read outstanding
    do_pop(2);
    check("mid_count_pre", bus.count, 5);
    drive(1'b0, 1'b1);
    check("mid_ren", bus.ren, 1);
    check("mid_raddr", bus.raddr, 5);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1);
    check("mid_rst_ren", bus.ren, 0);
    check("mid_rst_wen", bus.wen, 0);
    tick();
    check("mid_rvalid", bus.rvalid, 0);
    check("mid_count", bus.count, 0);
    check("mid_error", bus.error, 0);
    check("mid_empty", bus.empty, 1);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
